fifo_ctrl: RTL

//  Pointer/flag controller driving the FIFO storage array: accepts push/pop requests,

---
 rtl/fifo_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: wrap-bit pointer/flag controller driving a FIFO storage array.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_ctrl #(
   parameter int FIFO_ADDRESS_SIZE = 2,
   parameter int MEMORY_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   output logic                       cw_en,
   output logic                       cr_en,
   output logic [FIFO_ADDRESS_SIZE:0] w_ptr,
   output logic [FIFO_ADDRESS_SIZE:0] r_ptr,
   output logic                       full,
   output logic                       empty,
   output logic [FIFO_ADDRESS_SIZE:0] count,
   output logic                       rvalid,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int A = FIFO_ADDRESS_SIZE;
   localparam logic [A:0] ONE = 1;
   logic [A:0] r_wptr, r_rptr, r_count;
   logic       r_rvalid;
   logic       w_full, w_empty;
   if (MEMORY_DEPTH != (1 << FIFO_ADDRESS_SIZE)) begin : g_bad_depth
      $error("fifo_ctrl: MEMORY_DEPTH must equal 2**FIFO_ADDRESS_SIZE");
   end
   always_comb begin
      w_empty = r_wptr == r_rptr;
      w_full  = (r_wptr[A] != r_rptr[A]) && (r_wptr[A-1:0] == r_rptr[A-1:0]);
   end
   // enables are forced low while reset is held so the memory sees no access
   assign cw_en  = push & ~w_full & ~rst;
   assign cr_en  = pop & ~w_empty & ~rst;
   assign w_ptr  = r_wptr;
   assign r_ptr  = r_rptr;
   assign full   = w_full;
   assign empty  = w_empty;
   assign count  = r_count;
   assign rvalid = r_rvalid;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         if (cw_en) r_wptr <= r_wptr + ONE;
         if (cr_en) r_rptr <= r_rptr + ONE;
         r_count  <= r_count + {{A{1'b0}}, cw_en} - {{A{1'b0}}, cr_en};
         r_rvalid <= cr_en;
      end
   end
`ifdef FIFO_ERR_FLAGS_EN
   logic r_ovf, r_unf;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (push & w_full) r_ovf <= 1'b1;
         if (pop & w_empty) r_unf <= 1'b1;
      end
   end
   assign overflow  = r_ovf;
   assign underflow = r_unf;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif
endmodule
